det_rr_sched: RTL and testbench
===============================

Name: det_rr_sched

Overview:
- Round-robin scheduler that shares one det3x3 determinant engine among N_REQ requesters.
- Arbitrates requests, latches the winner's 3x3 matrix and drives the engine's start/M inputs.
- Waits for the engine's done, then returns the determinant tagged with the requester id.
- Includes a watchdog so a hung engine cannot block the other requesters.
- Sits between requester blocks and a single det3x3 instance; the scheduler does not instantiate the engine.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, element and result width, two's complement, passed through unmodified.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the request is aborted with an error (>=2).
- IDW is a localparam, max(1, $clog2(N_REQ)).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester.
- req_m  in  N_REQ*9*W  matrices; element k (row-major, 0..8) of requester i at [(i*9+k)*W +: W].
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted and matrix latched.
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  IDW  requester index of the result.
- rsp_det  out  W  determinant; 0 when rsp_err=1.
- rsp_err  out  1  timeout abort flag, valid with rsp_valid.
- ctl_busy  out  1  high in every state except IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_m  out  9*W  latched matrix to the engine, element k at [k*W +: W].
- eng_det  in  W  engine result.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine done pulse.

Behaviour:
- Reset (async): every output is 0; eng_m register is 0; state=IDLE; priority pointer=0 (requester 0 has highest priority); timer=0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - Arbitration happens only when req!=0 and eng_busy=0.
  - Search starts at the priority pointer and wraps modulo N_REQ; the first set req bit wins.
  - At that edge: latch the winner's matrix into eng_m, record the id, and pulse gnt[id] for the following cycle.
  - Go to ISSUE.
  - eng_busy=1 blocks all grants; requests stay pending with no loss.
- ISSUE: eng_start=1 for exactly this cycle; clear the timer; go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - eng_done=1: capture eng_det into rsp_det, set rsp_err=0, go to RESP.
  - Else, when the timer reaches TIMEOUT_CYCLES: set rsp_det=0, rsp_err=1, go to RESP.
  - eng_done on the same edge as the timeout: done wins, no error.
- RESP:
  - rsp_valid=1 with rsp_id, rsp_det and rsp_err for one cycle.
  - Priority pointer becomes (id+1) mod N_REQ.
  - Go to IDLE.
  - rsp_det and rsp_err hold their values until the next RESP; only rsp_valid pulses.
- Latency:
  - Request sampled at edge T.
  - gnt high during T..T+1; eng_start high during T+1..T+2.
  - eng_done sampled at edge D gives rsp_valid during D..D+1.
  - Earliest next grant at edge D+2.
- Requester protocol:
  - Hold req and req_m stable until gnt, then drop req the next cycle.
  - req_m may change after gnt because the matrix is latched.
  - A req still high in IDLE is treated as a new request.
- eng_done outside WAIT is ignored, including a late done after a timeout.
- A req that falls before being granted is silently withdrawn.
- Reset mid-operation aborts the transaction; no rsp_valid is produced for it.
- Only one transaction is in flight at a time; no queueing.

Test Plan:
- Single request: req=0010 with matrix {-5,-5,-5,-5,-5,-4,-5,-3,-5} and a behavioural det3x3 -> gnt=0010 for 1 cycle, exactly one eng_start pulse, eng_m matches the matrix, rsp_valid once with rsp_id=1, rsp_det=10, rsp_err=0.
- Simultaneous requests after reset: req=1111 with identity, diag(2,3,4), diag(-1,1,1) and all-zeros matrices -> served in order 0,1,2,3 with rsp_det=1,24,-1,0; each gnt comes only after the previous rsp_valid.
- Rotation: after serving id 1, req=0101 in the same cycle -> id 2 granted first, then id 0.
- Timeout: TIMEOUT_CYCLES=16 and the engine never asserts done -> rsp_valid with rsp_err=1, rsp_det=0 on the 16th WAIT cycle; a later injected eng_done produces no response.
- Busy gate: eng_busy=1 for 20 cycles with req=1000 -> no gnt and no eng_start; gnt[3] arrives on the first edge after eng_busy falls.
- Reset mid-WAIT: assert reset, then deliver eng_done -> all outputs 0 and no rsp_valid; then req=1000 with identity -> rsp_id=3, rsp_det=1.

Source files
------------

// File: rtl/det_rr_sched.sv
// Round-robin front end that time-shares one det3x3 engine among N_REQ requesters,
// with a WAIT watchdog so a hung engine cannot starve the others.
//
// state | meaning
// IDLE  | arbitrate pending requests while the engine is not busy
// ISSUE | pulse eng_start for the latched matrix, clear the watchdog
// WAIT  | wait for eng_done or watchdog expiry
// RESP  | present the tagged result, advance the priority pointer
module det_rr_sched #(
   parameter int N_REQ          = 4,
   parameter int W              = 32,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int IDW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*9*W-1:0]   req_m,
   output logic [N_REQ-1:0]       gnt,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [W-1:0]           rsp_det,
   output logic                   rsp_err,
   output logic                   ctl_busy,
   output logic                   eng_start,
   output logic [9*W-1:0]         eng_m,
   input  logic [W-1:0]           eng_det,
   input  logic                   eng_busy,
   input  logic                   eng_done
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDW:0]  N_REQ_W   = (IDW+1)'(N_REQ);
   localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   cur_id;
   logic [TW-1:0]    timer;
   logic [TW-1:0]    timer_inc;
   logic [IDW:0]     id_inc;
   logic [IDW-1:0]   ptr_nxt;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [N_REQ-1:0] gnt_sel;
   logic [9*W-1:0]   m_sel;

   // Two passes give the wrap-around search: first ids at/after the pointer, then ids below it.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req[i] && (IDW'(i) >= ptr)) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req[i] && (IDW'(i) < ptr)) begin
            win_found = 1'b1;
            win_id    = IDW'(i);
         end
      end
   end

   always_comb begin
      gnt_sel = '0;
      m_sel   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDW'(i) == win_id) begin
            gnt_sel[i] = 1'b1;
            m_sel      = req_m[i*9*W +: 9*W];
         end
      end
   end

   assign timer_inc = timer + TW'(1);
   assign id_inc    = {1'b0, cur_id} + (IDW+1)'(1);
   assign ptr_nxt   = (id_inc == N_REQ_W) ? '0 : id_inc[IDW-1:0];
   assign ctl_busy  = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         cur_id    <= '0;
         timer     <= '0;
         gnt       <= '0;
         eng_start <= 1'b0;
         eng_m     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_det   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         gnt       <= '0;
         eng_start <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (win_found && !eng_busy) begin
                  gnt    <= gnt_sel;
                  eng_m  <= m_sel;
                  cur_id <= win_id;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               eng_start <= 1'b1;
               timer     <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               timer <= timer_inc;
               // A done arriving on the expiry edge still counts as a good result.
               if (eng_done) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_det   <= eng_det;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (timer_inc == TIMEOUT_W) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= cur_id;
                  rsp_det   <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               ptr   <= ptr_nxt;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_det_rr_sched.sv
// Directed bench for det_rr_sched: a behavioural det3x3 stand-in answers eng_start,
// and every result is compared against hand-computed determinants.
module tb_det_rr_sched;

   localparam int N_REQ = 4;
   localparam int W     = 32;
   localparam int TO    = 16;
   localparam int IDW   = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N_REQ-1:0]     req;
   logic [N_REQ*9*W-1:0] req_m;
   logic [N_REQ-1:0]     gnt;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [W-1:0]         rsp_det;
   logic                 rsp_err;
   logic                 ctl_busy;
   logic                 eng_start;
   logic [9*W-1:0]       eng_m;
   logic [W-1:0]         eng_det;
   logic                 eng_busy;
   logic                 eng_done;

   int n_assert = 0;
   int n_fail   = 0;
   int mats [N_REQ][9];

   always #5 clk = ~clk;

   det_rr_sched #(.N_REQ(N_REQ), .W(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_m(req_m), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_det(rsp_det), .rsp_err(rsp_err),
      .ctl_busy(ctl_busy), .eng_start(eng_start), .eng_m(eng_m), .eng_det(eng_det),
      .eng_busy(eng_busy), .eng_done(eng_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [9*W-1:0] obs, input logic [9*W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pack_mats();
      for (int i = 0; i < N_REQ; i++)
         for (int k = 0; k < 9; k++)
            req_m[(i*9+k)*W +: W] = mats[i][k];
   endtask

   function automatic logic [9*W-1:0] mat_m(input int id);
      logic [9*W-1:0] r;
      for (int k = 0; k < 9; k++) r[k*W +: W] = mats[id][k];
      return r;
   endfunction

   function automatic int det3(input logic [9*W-1:0] m);
      int a [9];
      for (int k = 0; k < 9; k++) a[k] = m[k*W +: W];
      return a[0]*(a[4]*a[8]-a[5]*a[7]) - a[1]*(a[3]*a[8]-a[5]*a[6])
           + a[2]*(a[3]*a[7]-a[4]*a[6]);
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_id"}, rsp_id, 0);
      chk({tag, "_rsp_det"}, rsp_det, 0);
      chk({tag, "_rsp_err"}, rsp_err, 0);
      chk({tag, "_ctl_busy"}, ctl_busy, 0);
      chk({tag, "_eng_start"}, eng_start, 0);
      chk({tag, "_eng_m"}, eng_m, 0);
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < 50);
   endtask

   // Called just after the edge that raised gnt; completes the transaction with the engine
   // answering lat cycles after eng_start, and ends one cycle after rsp_valid.
   task automatic finish_txn(input int id, input int exp_det, input int lat);
      logic [N_REQ-1:0] g;
      logic [W-1:0]     e;
      int               starts;
      g = 1 << id;
      e = exp_det;
      chk("gnt_onehot", gnt, g);
      chk("eng_m_latched", eng_m, mat_m(id));
      req[id] = 1'b0;
      tick();
      chk("eng_start", eng_start, 1);
      chk("gnt_one_cycle", gnt, 0);
      chk("busy_active", ctl_busy, 1);
      eng_busy = 1'b1;
      starts = 0;
      repeat (lat) begin
         tick();
         if (eng_start) starts++;
      end
      eng_det  = det3(eng_m);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      eng_busy = 1'b0;
      chk("extra_start", starts, 0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, id);
      chk("rsp_det", rsp_det, e);
      chk("rsp_err", rsp_err, 0);
      tick();
      chk("rsp_valid_pulse", rsp_valid, 0);
      chk("gnt_after_rsp", gnt, 0);
      chk("busy_idle", ctl_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n, early, cnt_g, cnt_s, cnt_v;

      reset = 1'b1; req = '0; req_m = '0;
      eng_det = '0; eng_busy = 1'b0; eng_done = 1'b0;
      tick(); tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Single request from id 1, det = 10
      mats[1] = '{-5, -5, -5, -5, -5, -4, -5, -3, -5};
      pack_mats();
      req = 4'b0010;
      wait_gnt(n);
      chk("single_gnt_latency", n, 1);
      finish_txn(1, 10, 3);

      // Rotation: pointer now at 2, so id 2 beats id 0
      mats[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      mats[2] = '{-1, 0, 0, 0, 1, 0, 0, 0, 1};
      pack_mats();
      req = 4'b0101;
      wait_gnt(n);
      chk("rot_first_latency", n, 1);
      finish_txn(2, -1, 1);
      wait_gnt(n);
      chk("rot_second_latency", n, 1);
      finish_txn(0, 1, 0);

      // Timeout: engine never answers for id 3
      mats[3] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      pack_mats();
      req = 4'b1000;
      wait_gnt(n);
      chk("to_gnt", gnt, 4'b1000);
      req = '0;
      tick();
      chk("to_eng_start", eng_start, 1);
      early = 0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (rsp_valid && k < TO) early++;
      end
      chk("to_early_rsp", early, 0);
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_err", rsp_err, 1);
      chk("to_rsp_det", rsp_det, 0);
      chk("to_rsp_id", rsp_id, 3);
      tick();
      chk("to_rsp_pulse", rsp_valid, 0);
      eng_det = 32'h55; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      cnt_v = 0;
      repeat (4) begin
         tick();
         if (rsp_valid) cnt_v++;
      end
      chk("late_done_no_rsp", cnt_v, 0);
      chk("late_done_det_held", rsp_det, 0);
      chk("late_done_err_held", rsp_err, 1);
      chk("late_done_idle", ctl_busy, 0);

      // Busy gate: 20 cycles of eng_busy hold off the grant
      eng_busy = 1'b1;
      req = 4'b1000;
      cnt_g = 0; cnt_s = 0;
      repeat (20) begin
         tick();
         if (gnt != '0) cnt_g++;
         if (eng_start) cnt_s++;
      end
      chk("busy_no_gnt", cnt_g, 0);
      chk("busy_no_start", cnt_s, 0);
      eng_busy = 1'b0;
      tick();
      chk("busy_release_gnt", gnt, 4'b1000);
      finish_txn(3, 1, 2);

      // Reset in WAIT, then a stray done
      req = 4'b0010;
      wait_gnt(n);
      chk("rst_gnt", gnt, 4'b0010);
      req = '0;
      tick(); tick(); tick();
      chk("rst_in_wait", ctl_busy, 1);
      reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      tick();
      reset = 1'b0;
      eng_det = 32'd77; eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      cnt_v = 0;
      repeat (3) begin
         tick();
         if (rsp_valid) cnt_v++;
      end
      chk("midrst_no_rsp", cnt_v, 0);
      chk("midrst_idle", ctl_busy, 0);
      req = 4'b1000;
      wait_gnt(n);
      chk("midrst_gnt_latency", n, 1);
      finish_txn(3, 1, 1);

      // All four request together after reset: served 0,1,2,3
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mats[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
      mats[1] = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
      mats[2] = '{-1, 0, 0, 0, 1, 0, 0, 0, 1};
      mats[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      pack_mats();
      req = 4'b1111;
      wait_gnt(n);
      chk("all_gnt0_latency", n, 1);
      finish_txn(0, 1, 2);
      wait_gnt(n);
      chk("all_gnt1_latency", n, 1);
      finish_txn(1, 24, 2);
      wait_gnt(n);
      chk("all_gnt2_latency", n, 1);
      finish_txn(2, -1, 2);
      wait_gnt(n);
      chk("all_gnt3_latency", n, 1);
      finish_txn(3, 0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
